// File: rtl/wr_ingress_pkg.sv
// Shared types and helpers for the write-domain ingress stage of the async FIFO.
package wr_ingress_pkg;

    // Skid buffer occupancy; only 0..2 are reachable.
    typedef logic [1:0] skid_cnt_t;

    localparam skid_cnt_t SKID_EMPTY = 2'd0;
    localparam skid_cnt_t SKID_ONE   = 2'd1;
    localparam skid_cnt_t SKID_FULL  = 2'd2;

    // Gray to binary by XOR-prefix from the MSB down; bits at or above width read as zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] bin;
        logic        acc;
        bin = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < int'(width)) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/wr_ingress_ctrl_if.sv
// Bus bundle between the producer/pointer block (master) and wr_ingress_ctrl (slave).
// Handshake: a word moves on s_valid && s_ready at a wclk edge; a write happens on winc && !wfull.
interface wr_ingress_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  wfull;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH:0]   wcount;
    logic                  walmost_full;
    logic                  wptr_err;
    wr_ingress_pkg::skid_cnt_t skid_count;

    modport master (
        output s_valid, s_data, wfull, wptr, wq2_rptr,
        input  s_ready, winc, wdata, wcount, walmost_full, wptr_err, skid_count
    );

    modport slave (
        input  s_valid, s_data, wfull, wptr, wq2_rptr,
        output s_ready, winc, wdata, wcount, walmost_full, wptr_err, skid_count
    );
endinterface

// File: rtl/wr_skid_buf.sv
// Two-entry skid buffer feeding winc/wdata; s_ready is registered from the next count.
module wr_skid_buf
    import wr_ingress_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output skid_cnt_t             count
);
    logic [DATA_WIDTH-1:0] head, tail, head_next, tail_next;
    skid_cnt_t             count_next;
    logic                  push, pop;

    assign winc  = (count != SKID_EMPTY);
    assign wdata = head;
    assign push  = s_valid && s_ready;
    assign pop   = winc && !wfull;

    // Head always holds the oldest word; tail is only meaningful at count 2.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        case ({push, pop})
            2'b10: begin
                if (count == SKID_EMPTY) begin
                    head_next  = s_data;
                    count_next = SKID_ONE;
                end else begin
                    tail_next  = s_data;
                    count_next = SKID_FULL;
                end
            end
            2'b01: begin
                head_next  = tail;
                count_next = count - 2'd1;
            end
            2'b11: begin
                if (count == SKID_ONE) begin
                    head_next = s_data;
                end else begin
                    head_next = tail;
                    tail_next = s_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            head    <= '0;
            tail    <= '0;
            count   <= SKID_EMPTY;
            s_ready <= 1'b0;
        end else begin
            head    <= head_next;
            tail    <= tail_next;
            count   <= count_next;
            s_ready <= (count_next != SKID_FULL);
        end
    end
endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-domain ingress: skid-buffered producer stream into the write-pointer/memory pair,
// plus registered occupancy, almost-full and a sticky pointer-consistency error.
module wr_ingress_ctrl
    import wr_ingress_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input logic              wclk,
    input logic              wrst,
    wr_ingress_ctrl_if.slave bus
);
    localparam int          PTR_W    = ADDR_WIDTH + 1;
    localparam logic [31:0] PTR_MASK = (32'd1 << PTR_W) - 32'd1;
    localparam logic [31:0] DEPTH    = 32'd1 << ADDR_WIDTH;
    localparam logic [31:0] AFULL_W  = 32'(AFULL_THRESH);

    logic [31:0] occ_next;

    wr_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .wclk    (wclk),
        .wrst    (wrst),
        .s_valid (bus.s_valid),
        .s_data  (bus.s_data),
        .s_ready (bus.s_ready),
        .wfull   (bus.wfull),
        .winc    (bus.winc),
        .wdata   (bus.wdata),
        .count   (bus.skid_count)
    );

    // Modular difference: wrap of either pointer is intended, the read side is stale-conservative.
    always_comb begin
        occ_next = (gray2bin(32'(bus.wptr), PTR_W) - gray2bin(32'(bus.wq2_rptr), PTR_W)) & PTR_MASK;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            bus.wcount       <= '0;
            bus.walmost_full <= 1'b0;
            bus.wptr_err     <= 1'b0;
        end else begin
            bus.wcount       <= occ_next[ADDR_WIDTH:0];
            bus.walmost_full <= (occ_next >= AFULL_W);
            if (occ_next > DEPTH) begin
                bus.wptr_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Directed and random checks of wr_ingress_ctrl against a queue-based reference model.
module tb_wr_ingress_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int AFT = 12;

    logic wclk, wrst;

    wr_ingress_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wr_ingress_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] exp_q[$];   // words the model holds, oldest first
    logic [DW-1:0] src_q[$];   // words still to offer
    logic [DW-1:0] dut_wr[$];  // words the DUT actually wrote
    int            wr_cyc[$];
    logic [DW-1:0] want[$];
    bit            ready_m, af_m, err_m, last_push;
    bit            valid_gate = 1'b1;
    int            occ_m;

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    function automatic int gray_of(input int i);
        return i ^ (i >> 1);
    endfunction

    function automatic int bin_of_gray(input int g);
        for (int i = 0; i < 32; i++) begin
            if (gray_of(i) == g) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ready_m   = 1'b0;
        af_m      = 1'b0;
        err_m     = 1'b0;
        occ_m     = 0;
        last_push = 1'b0;
    endtask

    task automatic model_edge();
        bit push, pop;
        last_push = 1'b0;
        if (wrst) begin
            model_reset();
            return;
        end
        push = bus.s_valid && ready_m;
        pop  = (exp_q.size() != 0) && !bus.wfull;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(bus.s_data);
        last_push = push;
        ready_m   = (exp_q.size() < 2);
        occ_m     = (bin_of_gray(int'(bus.wptr)) - bin_of_gray(int'(bus.wq2_rptr)) + 32) % 32;
        af_m      = (occ_m >= AFT);
        if (occ_m > 16) err_m = 1'b1;
    endtask

    task automatic check_all();
        check("s_ready", 32'(bus.s_ready), 32'(ready_m));
        check("winc", 32'(bus.winc), 32'(exp_q.size() != 0));
        check("skid_count", 32'(bus.skid_count), 32'(exp_q.size()));
        if (exp_q.size() != 0) check("wdata", 32'(bus.wdata), 32'(exp_q[0]));
        check("wcount", 32'(bus.wcount), 32'(occ_m));
        check("walmost_full", 32'(bus.walmost_full), 32'(af_m));
        check("wptr_err", 32'(bus.wptr_err), 32'(err_m));
    endtask

    task automatic drive_src();
        bus.s_valid = (src_q.size() != 0) && valid_gate;
        bus.s_data  = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic cycle();
        if (!wrst && bus.winc && !bus.wfull) begin
            dut_wr.push_back(bus.wdata);
            wr_cyc.push_back(cyc);
        end
        @(posedge wclk);
        cyc++;
        model_edge();
        #1;
        check_all();
        if (last_push) void'(src_q.pop_front());
        drive_src();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(src_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic check_written(input string tag);
        check({tag, "_len"}, 32'(dut_wr.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < dut_wr.size(); i++) begin
            check(tag, 32'(dut_wr[i]), 32'(want[i]));
        end
    endtask

    initial begin
        int r, d;
        wrst         = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.wfull    = 1'b0;
        bus.wptr     = '0;
        bus.wq2_rptr = '0;
        model_reset();

        // Reset values
        repeat (2) @(posedge wclk);
        #1;
        check("rst_wdata", 32'(bus.wdata), 32'd0);
        check_all();
        wrst = 1'b0;

        // Continuous stream 0x01..0x10
        for (int i = 1; i <= 16; i++) src_q.push_back(DW'(i));
        drive_src();
        cycle();
        check("s_ready_first_edge", 32'(bus.s_ready), 32'd1);
        check("winc_before_accept", 32'(bus.winc), 32'd0);
        cycle();
        check("winc_after_accept", 32'(bus.winc), 32'd1);
        drain("stream", 40);
        want.delete();
        for (int i = 1; i <= 16; i++) want.push_back(DW'(i));
        check_written("stream_order");
        if (wr_cyc.size() == 16) check("stream_no_gaps", 32'(wr_cyc[15] - wr_cyc[0]), 32'd15);

        // Stall under wfull
        dut_wr.delete();
        wr_cyc.delete();
        bus.wfull = 1'b1;
        src_q.push_back(8'hA0);
        src_q.push_back(8'hA1);
        src_q.push_back(8'hA2);
        drive_src();
        repeat (2) cycle();
        repeat (5) cycle();
        check("stall_count", 32'(bus.skid_count), 32'd2);
        check("stall_s_ready", 32'(bus.s_ready), 32'd0);
        check("stall_winc", 32'(bus.winc), 32'd1);
        check("stall_wdata", 32'(bus.wdata), 32'hA0);
        bus.wfull = 1'b0;
        drain("stall", 20);
        want.delete();
        want.push_back(8'hA0);
        want.push_back(8'hA1);
        want.push_back(8'hA2);
        check_written("stall_order");

        // Simultaneous push/pop at count 1
        dut_wr.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(8'h30 + DW'(i));
        drive_src();
        cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("pp_count", 32'(bus.skid_count), 32'd1);
            check("pp_s_ready", 32'(bus.s_ready), 32'd1);
            check("pp_wdata", 32'(bus.wdata), 32'h31 + 32'(k));
        end
        drain("pushpop", 20);

        // Occupancy and almost-full
        bus.wptr     = 5'(gray_of(13));
        bus.wq2_rptr = 5'(gray_of(1));
        cycle();
        check("occ12_wcount", 32'(bus.wcount), 32'd12);
        check("occ12_afull", 32'(bus.walmost_full), 32'd1);
        bus.wq2_rptr = 5'(gray_of(2));
        cycle();
        check("occ11_wcount", 32'(bus.wcount), 32'd11);
        check("occ11_afull", 32'(bus.walmost_full), 32'd0);

        // Pointer wrap and error flag
        bus.wptr     = 5'(gray_of(3));
        bus.wq2_rptr = 5'(gray_of(29));
        cycle();
        check("wrap_wcount", 32'(bus.wcount), 32'd6);
        check("wrap_err", 32'(bus.wptr_err), 32'd0);
        bus.wptr     = 5'(gray_of(20));
        bus.wq2_rptr = 5'(gray_of(2));
        cycle();
        check("err_wcount", 32'(bus.wcount), 32'd18);
        check("err_set", 32'(bus.wptr_err), 32'd1);
        bus.wptr     = '0;
        bus.wq2_rptr = '0;
        repeat (2) cycle();
        check("err_sticky", 32'(bus.wptr_err), 32'd1);
        check("err_sticky_wcount", 32'(bus.wcount), 32'd0);

        // Reset mid-burst with two words buffered
        bus.wfull = 1'b1;
        src_q.push_back(8'h70);
        src_q.push_back(8'h71);
        src_q.push_back(8'h72);
        drive_src();
        repeat (3) cycle();
        check("pre_rst_count", 32'(bus.skid_count), 32'd2);
        #2;
        wrst = 1'b1;
        model_reset();
        src_q.delete();
        drive_src();
        #1;
        check("rst_async_winc", 32'(bus.winc), 32'd0);
        check("rst_async_count", 32'(bus.skid_count), 32'd0);
        cycle();
        wrst = 1'b0;
        check("post_rst_wcount", 32'(bus.wcount), 32'd0);
        check("post_rst_err", 32'(bus.wptr_err), 32'd0);
        dut_wr.delete();
        bus.wfull = 1'b0;
        src_q.push_back(8'h55);
        src_q.push_back(8'h56);
        drive_src();
        drain("post_rst", 20);
        want.delete();
        want.push_back(8'h55);
        want.push_back(8'h56);
        check_written("post_rst_order");

        // Random traffic, stalls and pointer pairs
        for (int k = 0; k < 400; k++) begin
            if (src_q.size() < 4) src_q.push_back(DW'($urandom_range(0, 255)));
            valid_gate   = ($urandom_range(0, 3) != 0);
            bus.wfull    = ($urandom_range(0, 3) == 0);
            r            = int'($urandom_range(0, 31));
            d            = int'($urandom_range(0, 17));
            bus.wq2_rptr = 5'(gray_of(r));
            bus.wptr     = 5'(gray_of((r + d) % 32));
            drive_src();
            cycle();
        end
        valid_gate = 1'b1;
        bus.wfull  = 1'b0;
        drive_src();
        drain("random", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wr_ingress_ctrl.md
# wr_ingress_ctrl

Write-domain ingress stage for the asynchronous FIFO, directly upstream of the write-pointer/full block. It accepts a valid/ready stream from the producer and buffers it in a 2-entry skid buffer. It drives the write-increment and write-data lines into the pointer/memory pair, and computes write-side occupancy and almost-full from the Gray write pointer and the synchronized Gray read pointer.

## Interface
- DATA_WIDTH, 8: width of a FIFO word.
- ADDR_WIDTH, 4: FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 12: occupancy at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.
- wclk  input  1  write-domain clock; the only clock.
- wrst  input  1  asynchronous, active-high reset.
- s_valid  input  1  producer word valid.
- s_data  input  DATA_WIDTH  producer word.
- s_ready  output  1  registered; block can take a word this cycle.
- wfull  input  1  registered full flag from the write-pointer block.
- wptr  input  ADDR_WIDTH+1  Gray write pointer from the write-pointer block.
- wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into wclk.
- winc  output  1  write request to the pointer block and memory.
- wdata  output  DATA_WIDTH  word written when winc && !wfull.
- wcount  output  ADDR_WIDTH+1  registered write-side occupancy, 0..2**ADDR_WIDTH.
- walmost_full  output  1  registered; wcount >= AFULL_THRESH.
- wptr_err  output  1  sticky; computed occupancy exceeded 2**ADDR_WIDTH.

## Operation
- Skid buffer: 2 entries (head, tail) with count 0..2.
- Push: s_valid && s_ready.
- Pop: winc && !wfull.
- winc = (count != 0), combinational from the count register. It is not gated by wfull; the downstream block gates it.
- wdata = head entry, a register.
- Push and pop in the same cycle: count is unchanged. The new word goes to the head if count was 1; otherwise it goes to the tail, which shifts to the head.
- Push into an empty buffer: the word lands in the head.
- s_ready register <= (count_next < 2). The buffer cannot overflow; a push when count==2 is impossible by construction.
- wfull held high: count saturates at 2, s_ready drops, and winc stays high with wdata stable.
- Occupancy: wcount <= (gray2bin(wptr) - gray2bin(wq2_rptr)) mod 2**(ADDR_WIDTH+1).
  - Unsigned wrap is the intended behaviour across pointer wrap-around.
  - Occupancy is conservative: the read pointer is stale by the synchronizer delay.
- walmost_full <= (occupancy_next >= AFULL_THRESH).
- wptr_err sets when occupancy_next > 2**ADDR_WIDTH. It clears only on reset.
- Reset values: count 0, head/tail 0, wdata 0, winc 0, s_ready 0, wcount 0, walmost_full 0, wptr_err 0.
- Reset mid-operation: buffered words are discarded and winc falls asynchronously with wrst.

## Timing
- Word accepted at edge N: winc is high and wdata carries it from edge N until the edge where it is popped. The earliest write is therefore at edge N+1.
- Throughput: one word per cycle while wfull stays low.
- s_ready rises at the first wclk edge after wrst deasserts.
- wcount and walmost_full lag the pointer inputs by 1 cycle.
- wfull asserted at edge M: no pop at edge M+1; winc and wdata are held.
- Pointer inputs that change at the same edge as a push or pop are sampled independently. There is no ordering between buffer and occupancy logic.

## Structure
- Package wr_ingress_pkg holds:
  - the gray2bin function, parameterized by width (XOR-prefix, MSB down);
  - the skid-count typedef (2-bit, values 0..2).
- Sub-module wr_skid_buf holds the 2-entry buffer, count, s_ready register and head/tail muxing.
- The top level holds the occupancy, almost-full and error logic and instantiates wr_skid_buf.

## Test plan
- Reset, then s_valid=1 with data 0x01..0x10, wfull=0: s_ready rises at the first edge; winc first asserts one cycle after the first accept; wdata sequence is 0x01..0x10 with no gaps.
- Stall: fill with 0xA0, 0xA1, 0xA2, then raise wfull for 5 cycles.
  - count reaches 2 and s_ready goes 0.
  - winc stays 1 and wdata holds 0xA0.
  - After wfull drops, 0xA0, 0xA1, 0xA2 are written in order and none is lost.
- Occupancy: wptr=gray(13), wq2_rptr=gray(1) gives wcount=12 and walmost_full=1 next cycle. wq2_rptr=gray(2) then gives 11 and 0.
- Wrap: wptr=gray(3), wq2_rptr=gray(29) gives wcount=6, wptr_err=0. wptr=gray(20), wq2_rptr=gray(2) gives 18: wptr_err=1 and stays set.
- Reset mid-burst with 2 words buffered: winc=0 immediately. After release, wcount=0 and the first written word is the first one pushed after reset.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, wdata advances one word per cycle, s_ready stays 1.
